// File: rtl/lzc_pkg.sv
// Shared constants and types for the leading-zero counter.
// Used by lzc_unit and its nibble sub-block.
package lzc_pkg;

  localparam int LZC_WIDTH = 24;
  localparam int LZC_CNT_W = 5;

  typedef logic [LZC_WIDTH:1]   lzc_mant_t;
  typedef logic [LZC_CNT_W-1:0] lzc_cnt_t;

endpackage

// File: rtl/lzc_nibble.sv
// 4-bit leading-zero count with all-zero flag.
// Leaf of the lzc_unit priority tree.
module lzc_nibble (
  input  logic [3:0] d,
  output logic [1:0] cnt,
  output logic       zero
);

  // first set bit from the top of the nibble
  always_comb begin
    cnt  = 2'd0;
    zero = 1'b0;
    priority case (1'b1)
      d[3]:    cnt = 2'd0;
      d[2]:    cnt = 2'd1;
      d[1]:    cnt = 2'd2;
      d[0]:    cnt = 2'd3;
      default: zero = 1'b1;
    endcase
  end

endmodule

// File: rtl/lzc_unit.sv
// Registered leading-zero counter for FPU normalisation.
// LZC_INPUT_REG_EN adds an input register stage (latency 2).
module lzc_unit
  import lzc_pkg::*;
#(
  parameter int WIDTH = LZC_WIDTH,
  parameter int CNT_W = LZC_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH:1]   AdderResult,
  output logic             out_valid,
  output logic [CNT_W-1:0] Shifts,
  output logic             Zero
);

  localparam int NIB  = (WIDTH + 3) / 4;
  localparam int PW   = NIB * 4;
  localparam int PADW = PW - WIDTH;

  logic           valid_s;
  logic [WIDTH:1] mant_s;

`ifdef LZC_INPUT_REG_EN
  logic           in_valid_q, in_valid_d;
  logic [WIDTH:1] mant_q, mant_d;

  // input stage loads only on valid beats
  always_comb begin
    in_valid_d = in_valid;
    mant_d     = mant_q;
    if (in_valid) mant_d = AdderResult;
  end

  // input stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_q <= 1'b0;
      mant_q     <= '0;
    end else begin
      in_valid_q <= in_valid_d;
      mant_q     <= mant_d;
    end
  end

  assign valid_s = in_valid_q;
  assign mant_s  = mant_q;
`else
  assign valid_s = in_valid;
  assign mant_s  = AdderResult;
`endif

  // Low-end pad of 1s; all-zero is handled by the Zero path.
  logic [PW-1:0] pad_w;
  generate
    if (PADW == 0) begin : g_nopad
      assign pad_w = mant_s;
    end else begin : g_pad
      assign pad_w = {mant_s, {PADW{1'b1}}};
    end
  endgenerate

  logic [1:0] nib_cnt  [NIB];
  logic       nib_zero [NIB];

  genvar k;
  generate
    for (k = 0; k < NIB; k++) begin : g_nib
      lzc_nibble u_nib (
        .d    (pad_w[PW-1-4*k -: 4]),
        .cnt  (nib_cnt[k]),
        .zero (nib_zero[k])
      );
    end
  endgenerate

  logic [CNT_W-1:0] cnt_w;
  logic             zero_w;

  // pick first non-zero nibble from the top
  always_comb begin
    logic found;
    found = 1'b0;
    cnt_w = CNT_W'(WIDTH);
    for (int i = 0; i < NIB; i++) begin
      if (!found && !nib_zero[i]) begin
        found = 1'b1;
        cnt_w = CNT_W'(4 * i) + CNT_W'(nib_cnt[i]);
      end
    end
    zero_w = ~|mant_s;
    if (zero_w) cnt_w = CNT_W'(WIDTH);
  end

  logic [CNT_W-1:0] shifts_q, shifts_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;

  // results load on valid, hold otherwise
  always_comb begin
    out_valid_d = valid_s;
    shifts_d    = shifts_q;
    zero_d      = zero_q;
    if (valid_s) begin
      shifts_d = cnt_w;
      zero_d   = zero_w;
    end
  end

  // output registers, reset wins
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      shifts_q    <= '0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      shifts_q    <= shifts_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Shifts    = shifts_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_lzc_unit.sv
// Self-checking bench for lzc_unit: vector table,
// hand sequences and randomized reference-model run.
module tb_lzc_unit;
  import lzc_pkg::*;

`ifdef LZC_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      in_valid = 1'b0;
  lzc_mant_t AdderResult = '0;
  logic      out_valid;
  lzc_cnt_t  Shifts;
  logic      Zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lzc_unit dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .AdderResult (AdderResult),
    .out_valid   (out_valid),
    .Shifts      (Shifts),
    .Zero        (Zero)
  );

  // reference: index of highest set bit, WIDTH - p
  function automatic int ref_cnt(input lzc_mant_t m);
    for (int p = LZC_WIDTH; p >= 1; p--)
      if (m[p]) return LZC_WIDTH - p;
    return LZC_WIDTH;
  endfunction

  // model state
  logic      m_valid = 1'b0;
  int        m_shifts = 0;
  logic      m_zero = 1'b0;
  logic      s_valid = 1'b0;
  lzc_mant_t s_mant = '0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input lzc_mant_t m,
                      input logic r);
    logic      lv;
    lzc_mant_t lm;
    in_valid    = v;
    AdderResult = m;
    rst         = r;
    @(posedge clk);
    if (r) begin
      m_valid  = 1'b0;
      m_shifts = 0;
      m_zero   = 1'b0;
      s_valid  = 1'b0;
      s_mant   = '0;
    end else begin
      if (LAT == 2) begin
        lv = s_valid;
        lm = s_mant;
        s_valid = v;
        if (v) s_mant = m;
      end else begin
        lv = v;
        lm = m;
      end
      m_valid = lv;
      if (lv) begin
        m_shifts = ref_cnt(lm);
        m_zero   = (lm == '0);
      end
    end
    #1;
    check("mdl_valid", int'(out_valid), int'(m_valid));
    check("mdl_shifts", int'(Shifts), m_shifts);
    check("mdl_zero", int'(Zero), int'(m_zero));
  endtask

  typedef struct {
    lzc_mant_t mant;
    int        shifts;
    logic      zero;
  } vec_t;

  vec_t vt[$];

  initial begin
    vec_t      e;
    lzc_mant_t rm;

    for (int i = 0; i < 24; i++) begin
      e.mant   = lzc_mant_t'(32'h1 << i);
      e.shifts = 23 - i;
      e.zero   = 1'b0;
      vt.push_back(e);
    end
    e.mant = 24'h000000; e.shifts = 24; e.zero = 1'b1; vt.push_back(e);
    e.mant = lzc_mant_t'(32'h1 << 24); e.shifts = 24; e.zero = 1'b1;
    vt.push_back(e);
    e.mant = lzc_mant_t'(32'h1 << 25); e.shifts = 24; e.zero = 1'b1;
    vt.push_back(e);
    e.mant = 24'h0FFFFF; e.shifts = 4;  e.zero = 1'b0; vt.push_back(e);
    e.mant = 24'h00FFFF; e.shifts = 8;  e.zero = 1'b0; vt.push_back(e);
    e.mant = 24'h000801; e.shifts = 12; e.zero = 1'b0; vt.push_back(e);
    e.mant = 24'hFFFFFF; e.shifts = 0;  e.zero = 1'b0; vt.push_back(e);

    // reset held with in_valid high
    step(1'b1, 24'hABCDEF, 1'b1);
    step(1'b1, 24'hABCDEF, 1'b1);
    check("rst_valid", int'(out_valid), 0);
    check("rst_shifts", int'(Shifts), 0);
    check("rst_zero", int'(Zero), 0);
    step(1'b1, 24'h800000, 1'b0);
    if (LAT == 2) begin
      check("first_lat_gap", int'(out_valid), 0);
      step(1'b0, 24'h000000, 1'b0);
    end
    check("first_valid", int'(out_valid), 1);
    check("first_shifts", int'(Shifts), 0);
    step(1'b0, 24'h000000, 1'b0);

    // vector table
    foreach (vt[i]) begin
      step(1'b1, vt[i].mant, 1'b0);
      for (int j = 1; j < LAT; j++) step(1'b0, 24'h000000, 1'b0);
      check($sformatf("tbl%0d_valid", i), int'(out_valid), 1);
      check($sformatf("tbl%0d_shifts", i), int'(Shifts), vt[i].shifts);
      check($sformatf("tbl%0d_zero", i), int'(Zero), int'(vt[i].zero));
    end

    // single-cycle valid pulse then idle
    step(1'b0, 24'h000000, 1'b0);
    step(1'b1, 24'h400000, 1'b0);
    for (int j = 1; j < LAT; j++) step(1'b0, 24'h000000, 1'b0);
    check("pulse_valid", int'(out_valid), 1);
    check("pulse_shifts", int'(Shifts), 1);
    for (int j = 0; j < 3; j++) begin
      step(1'b0, 24'hFFFFFF, 1'b0);
      check("idle_valid", int'(out_valid), 0);
      check("idle_shifts", int'(Shifts), 1);
      check("idle_zero", int'(Zero), 0);
    end

    // back-to-back stream, reset during the third beat
    step(1'b1, 24'h800000, 1'b0);
    if (LAT == 1) begin
      check("b2b0_valid", int'(out_valid), 1);
      check("b2b0_shifts", int'(Shifts), 0);
    end else begin
      check("b2b0_valid", int'(out_valid), 0);
    end
    step(1'b1, 24'h000001, 1'b0);
    check("b2b1_valid", int'(out_valid), 1);
    check("b2b1_shifts", int'(Shifts), (LAT == 1) ? 23 : 0);
    step(1'b1, 24'h000000, 1'b1);
    check("b2b_rst_valid", int'(out_valid), 0);
    check("b2b_rst_shifts", int'(Shifts), 0);
    check("b2b_rst_zero", int'(Zero), 0);
    step(1'b0, 24'h000000, 1'b0);
    check("b2b_flush_valid", int'(out_valid), 0);
    check("b2b_flush_shifts", int'(Shifts), 0);

    // randomized run with occasional reset
    for (int n = 0; n < 400; n++) begin
      rm = lzc_mant_t'($urandom);
      rm = rm >> $urandom_range(0, 24);
      step(1'($urandom_range(0, 3) != 0), rm,
           1'($urandom_range(0, 40) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lzc_unit.md
Name: lzc_unit

Overview:
- Leading-zero counter for the FPU add/sub datapath. Counts zeros from the MSB of the adder result, AdderResult[24], down to the first 1.
- The count is the left-shift amount the normaliser needs to bring the leading 1 into bit 24.
- Output is registered: one clock, synchronous active-high reset. The block sits between the mantissa adder and the normalisation shifter.

Parameters:
- WIDTH, 24, number of adder-result bits; the vector is indexed [WIDTH:1].
- CNT_W, 5, width of Shifts; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  AdderResult is valid this cycle.
- AdderResult  input  WIDTH [WIDTH:1]  adder output to be normalised.
- out_valid  output  1  Shifts and Zero are valid.
- Shifts  output  CNT_W  leading-zero count.
- Zero  output  1  AdderResult was all zeros.

Behaviour:
- Combinational count: Shifts_next = WIDTH − p, where p is the index (1..WIDTH) of the highest set bit. Examples:
  - Bit 24 set → 0.
  - Only bit 1 set → 23.
  - Lower bits are don't-care once a higher 1 exists.
- All-zero input: Shifts_next = WIDTH (24), Zero_next = 1. Otherwise Zero_next = 0.
- Latency is 1 cycle. On a rising edge with in_valid=1, Shifts/Zero load their next values and out_valid becomes 1 on the following cycle.
- When in_valid=0: out_valid becomes 0 and Shifts/Zero hold their previous values.
- No backpressure; a new input is accepted every cycle, giving full throughput.
- Reset: when rst=1 at a rising edge, Shifts=0, Zero=0, out_valid=0. Reset has priority over in_valid.
- A result in flight when reset is asserted is discarded.
- Outputs change only on clock edges. No combinational path exists from inputs to outputs.
- No X-propagation handling is required. Inputs must be known whenever in_valid=1.

Optional Feature:
- Macro: LZC_INPUT_REG_EN.
- Defined:
  - in_valid and AdderResult are first captured in an input register stage, giving latency 2.
  - That stage has the same reset rule (cleared to 0) and the same valid-gating.
  - out_valid follows in_valid by exactly 2 cycles.
- Undefined: latency is 1 as described above.
- Count/Zero semantics are identical in both builds.

Decomposition:
- Package lzc_pkg holds:
  - Constants LZC_WIDTH=24 and LZC_CNT_W=5.
  - typedef lzc_mant_t (logic [LZC_WIDTH:1]).
  - typedef lzc_cnt_t (logic [LZC_CNT_W-1:0]).
- Sub-module lzc_nibble: 4-bit input → 2-bit leading-zero count plus an all-zero flag.
- lzc_unit instantiates six lzc_nibble for the 24-bit case, then uses a priority-combine stage to pick the first non-zero nibble.
- The result is count = 4·(zero nibbles above) + nibble count.
- A generic WIDTH pads the low end with 1s up to a multiple of 4. The pad value is irrelevant except in the all-zero case, which is handled by the Zero path forcing Shifts=WIDTH.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 → out_valid=0, Shifts=0, Zero=0. Deassert rst → first result appears one cycle later.
- Walking one: for i=0..23 apply AdderResult=1<<i with in_valid=1 → one cycle later Shifts=23−i, Zero=0. Bit 24 set gives 0; only bit 1 set gives 23.
- All zeros: AdderResult=24'h000000 → Shifts=24, Zero=1. Also cover truncated 1<<24 and 1<<25, which give 24 and Zero=1.
- Don't-care lows: AdderResult=24'h0FFFFF → Shifts=4. 24'h00FFFF → 8. 24'h000801 → 12.
- Valid gating: pulse in_valid for one cycle with 24'h400000, then hold in_valid=0 → out_valid high for exactly one cycle and Shifts stays 1 afterwards.
- Back-to-back plus mid-stream reset: stream 24'h800000, 24'h000001, 24'h000000 on consecutive cycles, asserting rst during the third → Shifts 0, 23, then reset values and out_valid=0. With LZC_INPUT_REG_EN defined, repeat and check latency 2.
